// File: rtl/rop_lane_regfile.sv
// rop_lane_regfile: lane-addressable register file with a built-in clear sequencer.
// Optional macro ROP_REGFILE_BYPASS_EN forwards same-cycle writes/clears to reads.
module rop_lane_regfile #(
    parameter int NREGS  = 32,
    parameter int XLEN   = 32,
    parameter int LANE_W = 8,
    localparam int RAW    = $clog2(NREGS),
    localparam int NLANES = XLEN / LANE_W,
    localparam int LAW    = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [RAW-1:0]  a_reg_addr,
    input  logic            a_lane,
    input  logic [LAW-1:0]  a_lane_addr,
    input  logic            a_sext,
    output logic [XLEN-1:0] a_rdata,
    input  logic [RAW-1:0]  b_reg_addr,
    input  logic            b_lane,
    input  logic [LAW-1:0]  b_lane_addr,
    input  logic            b_sext,
    output logic [XLEN-1:0] b_rdata,
    input  logic            c_wen,
    output logic            c_ready,
    input  logic [RAW-1:0]  c_reg_addr,
    input  logic            c_lane,
    input  logic [LAW-1:0]  c_lane_addr,
    input  logic [XLEN-1:0] c_wdata,
    input  logic            clear_req,
    output logic            clear_busy,
    output logic            clear_done
);

    localparam logic [XLEN-1:0] LO_MASK = XLEN'({LANE_W{1'b1}});
    localparam logic [RAW-1:0]  LAST    = RAW'(NREGS - 1);
    localparam logic [RAW-1:0]  FIRST   = RAW'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [RAW-1:0]  ptr;
    logic [RAW-1:0]  ptr_n;
    logic            busy;
    logic            commit;
    logic [XLEN-1:0] c_old;
    logic [XLEN-1:0] c_merged;
    logic [XLEN-1:0] a_word;
    logic [XLEN-1:0] b_word;

    // Entry 0 is never written; reads of register 0 are forced to zero.
    logic [XLEN-1:0] regs [NREGS];

    // Pick one lane out of a word and widen it, or pass the whole word.
    function automatic logic [XLEN-1:0] lane_view(
        input logic [XLEN-1:0] w,
        input logic            lane,
        input logic [LAW-1:0]  la,
        input logic            sext
    );
        logic [LANE_W-1:0] v;
        logic [XLEN-1:0]   r;
        logic              hit;
        v   = '0;
        hit = 1'b0;
        if (!lane || NLANES == 1) return w;
        for (int l = 0; l < NLANES; l++) begin
            if (la == LAW'(l)) begin
                v   = w[l*LANE_W +: LANE_W];
                hit = 1'b1;
            end
        end
        r = '0;
        r[LANE_W-1:0] = v;
        if (sext && v[LANE_W-1]) r = r | ~LO_MASK;
        if (!hit) r = '0;
        return r;
    endfunction

    assign busy       = (state == CLEAR);
    assign clear_busy = busy;
    assign c_ready    = !busy;
    assign commit     = c_wen && c_ready && (c_reg_addr != '0);

    // Clear sequencer state and pointer; reset restarts the clear at register 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= CLEAR;
            ptr   <= FIRST;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end

    // Clear sequencer next state; a request while clearing is ignored.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        clear_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    ptr_n   = FIRST;
                end
            end
            CLEAR: begin
                ptr_n = ptr + FIRST;
                if (ptr == LAST) begin
                    state_n    = IDLE;
                    clear_done = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Post-write value of the write target: whole word or one lane merged in.
    always_comb begin
        c_old    = (c_reg_addr == '0) ? '0 : regs[c_reg_addr];
        c_merged = c_old;
        if (!c_lane || NLANES == 1) begin
            c_merged = c_wdata;
        end else begin
            for (int l = 0; l < NLANES; l++) begin
                if (c_lane_addr == LAW'(l)) begin
                    c_merged[l*LANE_W +: LANE_W] = c_wdata[LANE_W-1:0];
                end
            end
        end
    end

    // Storage: the clear owns the write port while busy, else accepted writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            regs[ptr] <= '0;
        end else if (commit) begin
            regs[c_reg_addr] <= c_merged;
        end
    end

`ifdef ROP_REGFILE_BYPASS_EN
    // Port A word select, forwarding this cycle's clear or write.
    always_comb begin
        if (a_reg_addr == '0) a_word = '0;
        else if (busy && a_reg_addr == ptr) a_word = '0;
        else if (commit && a_reg_addr == c_reg_addr) a_word = c_merged;
        else a_word = regs[a_reg_addr];
    end

    // Port B word select, forwarding this cycle's clear or write.
    always_comb begin
        if (b_reg_addr == '0) b_word = '0;
        else if (busy && b_reg_addr == ptr) b_word = '0;
        else if (commit && b_reg_addr == c_reg_addr) b_word = c_merged;
        else b_word = regs[b_reg_addr];
    end
`else
    // Port A word select from stored state.
    always_comb begin
        if (a_reg_addr == '0) a_word = '0;
        else a_word = regs[a_reg_addr];
    end

    // Port B word select from stored state.
    always_comb begin
        if (b_reg_addr == '0) b_word = '0;
        else b_word = regs[b_reg_addr];
    end
`endif

    assign a_rdata = lane_view(a_word, a_lane, a_lane_addr, a_sext);
    assign b_rdata = lane_view(b_word, b_lane, b_lane_addr, b_sext);

endmodule

// File: tb/tb_rop_lane_regfile.sv
// tb_rop_lane_regfile: directed + randomized checks of rop_lane_regfile
// against a queue/array reference model.
module tb_rop_lane_regfile;

    localparam int NREGS  = 32;
    localparam int XLEN   = 32;
    localparam int LANE_W = 8;

    logic        clk;
    logic        resetn;
    logic [4:0]  a_reg_addr, b_reg_addr, c_reg_addr;
    logic        a_lane, b_lane, c_lane;
    logic [1:0]  a_lane_addr, b_lane_addr, c_lane_addr;
    logic        a_sext, b_sext;
    logic [31:0] a_rdata, b_rdata, c_wdata;
    logic        c_wen, c_ready, clear_req, clear_busy, clear_done;

    rop_lane_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN),
        .LANE_W(LANE_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .a_reg_addr (a_reg_addr),
        .a_lane     (a_lane),
        .a_lane_addr(a_lane_addr),
        .a_sext     (a_sext),
        .a_rdata    (a_rdata),
        .b_reg_addr (b_reg_addr),
        .b_lane     (b_lane),
        .b_lane_addr(b_lane_addr),
        .b_sext     (b_sext),
        .b_rdata    (b_rdata),
        .c_wen      (c_wen),
        .c_ready    (c_ready),
        .c_reg_addr (c_reg_addr),
        .c_lane     (c_lane),
        .c_lane_addr(c_lane_addr),
        .c_wdata    (c_wdata),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: register contents, whether each is defined,
    // and the list of registers a running clear still has to zero.
    logic [31:0] mdl [NREGS];
    bit          known [NREGS];
    int          clr_q [$];

    logic [31:0] s_a, s_b;
    logic        s_busy, s_ready;
    int          busy_cnt, done_cnt;

    task automatic start_clear();
        clr_q.delete();
        for (int r = 1; r < NREGS; r++) begin
            clr_q.push_back(r);
            known[r] = 1'b0;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic lane,
                                          input logic [1:0] la,
                                          input logic [31:0] wd);
        logic [31:0] r;
        if (!lane) return wd;
        r = old;
        r[int'(la)*8 +: 8] = wd[7:0];
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w,
                                           input logic lane,
                                           input logic [1:0] la,
                                           input logic sext);
        logic [31:0] b;
        if (!lane) return w;
        b = (w >> (int'(la) * 8)) & 32'hFF;
        if (sext && b[7]) b = b | 32'hFFFF_FF00;
        return b;
    endfunction

    function automatic bit get_word(input int a, input bit commit,
                                    output logic [31:0] w);
        w = '0;
        if (a == 0) return 1'b1;
`ifdef ROP_REGFILE_BYPASS_EN
        if (clr_q.size() != 0 && clr_q[0] == a) return 1'b1;
        if (commit && a == int'(c_reg_addr)) begin
            if (c_lane && !known[a]) return 1'b0;
            w = merge(mdl[a], c_lane, c_lane_addr, c_wdata);
            return 1'b1;
        end
`endif
        w = mdl[a];
        return known[a];
    endfunction

    task automatic cycle();
        bit          busy_e, done_e, commit;
        logic [31:0] w;
        int          r;
        @(negedge clk);
        busy_e = clr_q.size() != 0;
        done_e = resetn && clr_q.size() == 1;
        commit = c_wen && !busy_e && c_reg_addr != 0;
        chk("busy", clear_busy, busy_e);
        chk("ready", c_ready, !busy_e);
        chk("done", clear_done, done_e);
        if (get_word(a_reg_addr, commit, w))
            chk("rd_a", a_rdata, extend(w, a_lane, a_lane_addr, a_sext));
        if (get_word(b_reg_addr, commit, w))
            chk("rd_b", b_rdata, extend(w, b_lane, b_lane_addr, b_sext));
        s_a     = a_rdata;
        s_b     = b_rdata;
        s_busy  = clear_busy;
        s_ready = c_ready;
        if (clear_busy) busy_cnt++;
        if (clear_done) done_cnt++;
        @(posedge clk);
        if (resetn) begin
            if (commit) begin
                mdl[c_reg_addr] = merge(mdl[c_reg_addr], c_lane,
                                        c_lane_addr, c_wdata);
                if (!c_lane) known[c_reg_addr] = 1'b1;
            end
            if (busy_e) begin
                r = clr_q.pop_front();
                mdl[r]   = '0;
                known[r] = 1'b1;
            end else if (clear_req) begin
                start_clear();
            end
        end
        #1;
    endtask

    task automatic idle_in();
        c_wen       = 1'b0;
        c_lane      = 1'b0;
        c_lane_addr = '0;
        c_reg_addr  = '0;
        c_wdata     = '0;
        clear_req   = 1'b0;
        a_lane      = 1'b0;
        a_sext      = 1'b0;
        a_lane_addr = '0;
        b_lane      = 1'b0;
        b_sext      = 1'b0;
        b_lane_addr = '0;
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        start_clear();
        repeat (n) cycle();
        resetn = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!s_busy) return;
        end
        chk("idle_timeout", s_busy, 1'b0);
    endtask

    task automatic wr(input int a, input logic lane, input int la,
                      input logic [31:0] d);
        c_wen       = 1'b1;
        c_reg_addr  = 5'(a);
        c_lane      = lane;
        c_lane_addr = 2'(la);
        c_wdata     = d;
        cycle();
        c_wen = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        a_reg_addr = '0;
        b_reg_addr = '0;
        idle_in();
        for (int r = 0; r < NREGS; r++) begin
            mdl[r]   = '0;
            known[r] = (r == 0);
        end
        #1;

        // Reset and the initial clear.
        do_reset(3);
        wait_idle();
        chk("clr_len", busy_cnt, 31);
        chk("clr_done_cnt", done_cnt, 1);

        // Every register reads zero afterwards.
        for (int r = 0; r < NREGS; r++) begin
            a_reg_addr = 5'(r);
            b_reg_addr = 5'(NREGS - 1 - r);
            cycle();
        end
        chk("zero_a31", s_a, 32'h0);

        // Word write and lane reads.
        wr(5, 1'b0, 0, 32'hDEAD_BEEF);
        a_reg_addr = 5;
        cycle();
        chk("word_r5", s_a, 32'hDEAD_BEEF);
        a_lane = 1'b1; a_lane_addr = 2; a_sext = 1'b1;
        cycle();
        chk("lane2_sext", s_a, 32'hFFFF_FFAD);
        a_sext = 1'b0;
        cycle();
        chk("lane2_zext", s_a, 32'h0000_00AD);
        a_lane = 1'b0;

        // Lane write, then r0 write.
        wr(5, 1'b1, 1, 32'h0000_0012);
        cycle();
        chk("lane_wr_r5", s_a, 32'hDEAD_12EF);
        wr(0, 1'b0, 0, 32'hFFFF_FFFF);
        a_reg_addr = 0;
        cycle();
        chk("r0_zero", s_a, 32'h0);

        // Same-cycle read of a register being written.
        wr(7, 1'b0, 0, 32'h1111_1111);
        a_reg_addr = 7;
        b_reg_addr = 7;
        wr(7, 1'b0, 0, 32'hCAFE_F00D);
`ifdef ROP_REGFILE_BYPASS_EN
        chk("byp_a", s_a, 32'hCAFE_F00D);
        chk("byp_b", s_b, 32'hCAFE_F00D);
`else
        chk("old_a", s_a, 32'h1111_1111);
        chk("old_b", s_b, 32'h1111_1111);
`endif
        cycle();
        chk("new_a", s_a, 32'hCAFE_F00D);
        chk("new_b", s_b, 32'hCAFE_F00D);

        // Clear request; a write during the clear is dropped.
        wr(3, 1'b0, 0, 32'h3333_3333);
        wr(20, 1'b0, 0, 32'h2020_2020);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        cycle();
        wr(3, 1'b0, 0, 32'hABCD_0003);
        chk("ready_busy", s_ready, 1'b0);
        repeat (20) cycle();
        wr(20, 1'b0, 0, 32'hABCD_0020);
        wait_idle();
        chk("clr2_len", busy_cnt, 31);
        chk("clr2_done", done_cnt, 1);
        a_reg_addr = 3;
        b_reg_addr = 20;
        cycle();
        chk("r3_cleared", s_a, 32'h0);
        chk("r20_dropped", s_b, 32'h0);

        // Reset in the middle of a clear restarts it.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (10) cycle();
        do_reset(2);
        wait_idle();
        chk("rst_clr_len", busy_cnt, 31);
        chk("rst_clr_done", done_cnt, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            c_wen       = ($urandom_range(0, 1) == 1);
            c_reg_addr  = 5'($urandom);
            c_lane      = ($urandom_range(0, 2) == 0);
            c_lane_addr = 2'($urandom);
            c_wdata     = $urandom;
            clear_req   = ($urandom_range(0, 149) == 0);
            a_reg_addr  = ($urandom_range(0, 2) == 0) ? c_reg_addr
                                                      : 5'($urandom);
            a_lane      = 1'($urandom);
            a_lane_addr = 2'($urandom);
            a_sext      = 1'($urandom);
            b_reg_addr  = 5'($urandom);
            b_lane      = 1'($urandom);
            b_lane_addr = 2'($urandom);
            b_sext      = 1'($urandom);
            cycle();
        end
        idle_in();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rop_lane_regfile.md
# rop_lane_regfile

Parametrised lane-addressable general-purpose register file for the rop datapath. Register count, word width and lane width are generic. It provides two combinational read ports that return a whole word or a single lane, zero- or sign-extended, and one synchronous write port that writes a whole word or a single lane. A built-in clear sequencer zeroes every register after reset or on request, and stalls writes while it runs.

## Interface
- `NREGS`, default 32: number of registers; power of two, ≥ 4; register 0 reads zero.
- `XLEN`, default 32: word width in bits.
- `LANE_W`, default 8: lane width; one of 8, 16 or XLEN; must divide XLEN.
- Derived, not overridable: `RAW = clog2(NREGS)`, `NLANES = XLEN/LANE_W`, `LAW = max(1, clog2(NLANES))`.

Ports (name, direction, width, meaning):
- `clk`  in  1  global clock, rising edge.
- `resetn`  in  1  reset; asynchronous assert, active-low.
- `a_reg_addr`  in  RAW  port A register select.
- `a_lane`  in  1  1 = return the selected lane; 0 = return the whole word.
- `a_lane_addr`  in  LAW  lane index for port A.
- `a_sext`  in  1  1 = sign-extend the returned lane; 0 = zero-extend.
- `a_rdata`  out  XLEN  port A read data.
- `b_reg_addr`, `b_lane`, `b_lane_addr`, `b_sext`, `b_rdata`: port B, identical in form and behaviour to port A.
- `c_wen`  in  1  write request.
- `c_ready`  out  1  write accepted this cycle; low while clearing.
- `c_reg_addr`  in  RAW  write register select.
- `c_lane`  in  1  1 = write one lane; 0 = write the whole word.
- `c_lane_addr`  in  LAW  lane index for a lane write.
- `c_wdata`  in  XLEN  write data; for a lane write, bits [LANE_W-1:0] are used.
- `clear_req`  in  1  request a full clear.
- `clear_busy`  out  1  clear sequencer is active.
- `clear_done`  out  1  one-cycle pulse when a clear completes.

## Operation
- Storage: `NREGS-1` words (registers 1 to NREGS-1), held in flops with no reset; register 0 is hard-wired to zero.
- Read:
  - The selected word is `w`.
  - If the lane bit is 0, the port returns `w`.
  - If the lane bit is 1, the port returns lane `w[lane_addr*LANE_W +: LANE_W]`, extended to XLEN with zeros, or with its MSB when sext=1.
  - Lane addresses ≥ NLANES return zero.
  - When LANE_W equals XLEN, the lane bit is ignored.
- Write: a write commits on a rising edge when `c_wen && c_ready && c_reg_addr != 0`.
  - Word write: the whole register takes `c_wdata`.
  - Lane write: only the addressed lane takes `c_wdata[LANE_W-1:0]`; all other lanes hold.
  - A lane write with an out-of-range lane address changes nothing.
- Clear FSM has two states, IDLE and CLEAR, and a RAW-bit counter `ptr`.
  - Reset: the FSM enters CLEAR with `ptr=1`.
  - IDLE → CLEAR when `clear_req` is high; `ptr` loads 1.
  - In CLEAR, register `ptr` is zeroed each cycle and `ptr` increments.
  - After register NREGS-1 is zeroed, the FSM returns to IDLE and `clear_done` pulses for that one cycle.
  - `clear_req` while in CLEAR is ignored; the clear is not restarted.
- Outputs:
  - `c_ready = !clear_busy`.
  - `clear_busy` is high exactly while the state is CLEAR.
  - A `c_wen` presented while `c_ready` is low is dropped, not queued.
- Reads during CLEAR:
  - Registers already cleared read zero.
  - Registers not yet cleared return undefined data; the bench must not check them.

## Timing
- Reads: combinational, zero latency.
- Writes: visible on reads in the cycle after the commit edge. Same-cycle visibility is governed by the Configuration section.
- Clear length: a clear takes NREGS-1 cycles. For NREGS=32, `clear_busy` stays high for 31 cycles, and `clear_done` is asserted coincident with the final busy cycle.
- Reset values, while `resetn` is low: `clear_busy=1`, `c_ready=0`, `clear_done=0`; state CLEAR, `ptr=1`.
  - The first register is zeroed on the first rising edge after `resetn` deasserts.
- Reset asserted mid-clear: the sequence restarts from `ptr=1`.
- Simultaneous `clear_req` and `c_wen` in IDLE: the write commits on that edge; the clear starts on the same edge and will later overwrite the written register.

## Configuration
- `ROP_REGFILE_BYPASS_EN` defined:
  - A read whose register matches a committing write in the same cycle returns the post-write merged value combinationally.
  - Covers both lane writes and word writes.
  - Also covers the clear: a read of the register being zeroed this cycle returns zero.
- `ROP_REGFILE_BYPASS_EN` undefined: reads return the stored pre-edge value; there is no forwarding logic.

## Test plan
- Reset, then hold `resetn=1`: with NREGS=32, `clear_busy` stays high for 31 cycles and `clear_done` pulses once. Afterwards all 32 registers read 0x00000000.
- Word write 0xDEADBEEF to r5, then read A as word: returns 0xDEADBEEF. A lane read of lane 2 with sext=1 returns 0xFFFFFFAD; with sext=0 it returns 0x000000AD.
- Lane write 0x12 to r5 lane 1, then read as word: returns 0xDEAD12EF. A write of 0xFFFFFFFF to r0 still reads 0.
- Write r7 with port A and port B both reading r7 in the same cycle: with the macro, both read the new value that cycle. Without it, both read the old value, then the new value on the next cycle.
- `clear_req` pulse, then `c_wen` to r3 on the second busy cycle: `c_ready=0` and the write is dropped. After `clear_done`, r3 reads 0.
- Reset asserted at clear cycle 10: `clear_busy` stays high and the full 31-cycle sequence reruns after release.
